// File: rtl/mesh_pkg.sv
// rtl/mesh_pkg.sv - shared mesh phase constants and controller FSM encoding
package mesh_pkg;

  // Phase code broadcast to every processing element of the mesh
  localparam logic [1:0] GS_IDLE = 2'd0;
  localparam logic [1:0] GS_LOAD = 2'd1;
  localparam logic [1:0] GS_ACC  = 2'd2;
  localparam logic [1:0] GS_CAP  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ACC   = 3'd3,
    ST_CAP   = 3'd4,
    ST_DRAIN = 3'd5,
    ST_OUT   = 3'd6
  } ctrl_state_t;

endpackage

// File: rtl/mesh_array_ctrl.sv
// rtl/mesh_array_ctrl.sv - weight/vector sequencing controller for a 2-D MAC mesh (optional MESH_CTRL_PERF_EN)
module mesh_array_ctrl
  import mesh_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int ROW_W = 2,
  parameter int COL_W = 2,
  parameter int ACC_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic [DW-1:0]            w_data,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic [COLS*DW-1:0]       x_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ROWS*ACC_W-1:0]    res_data,
  output logic                     busy,
  output logic                     weights_loaded,
  output logic [COLS*DW-1:0]       mesh_x_vector_flat,
  output logic [1:0]               mesh_global_state,
  output logic                     mesh_cfg_valid,
  output logic [ROW_W+COL_W-1:0]   mesh_cfg_addr,
  output logic [DW-1:0]            mesh_cfg_data,
  input  logic [ROWS*ACC_W-1:0]    mesh_result_flat
`ifdef MESH_CTRL_PERF_EN
  ,
  output logic [31:0]              perf_vec_cnt
`endif
);

  localparam int PH_MAX = (ROWS > COLS) ? ROWS : COLS;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  ctrl_state_t       state;
  logic [ROW_W-1:0]  row_idx;
  logic [COL_W-1:0]  col_idx;
  logic [PH_W-1:0]   phase_cnt;
  logic              last_beat;
  logic              last_col;
  logic              w_fire;
  logic              x_fire;

  // Weights are only accepted while no vector is in flight
  assign w_ready   = (state == ST_IDLE) || (state == ST_CFG);
  assign busy      = (state != ST_IDLE);
  // A pending weight beat blocks vector acceptance so a reload always wins
  assign x_ready   = (state == ST_IDLE) && weights_loaded && !w_valid;
  assign w_fire    = w_valid && w_ready;
  assign x_fire    = x_valid && x_ready;
  assign last_col  = (col_idx == COL_W'(COLS - 1));
  assign last_beat = (row_idx == ROW_W'(ROWS - 1)) && last_col;

  // Controller FSM with beat/phase counters and all registered mesh/result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      row_idx            <= '0;
      col_idx            <= '0;
      phase_cnt          <= '0;
      weights_loaded     <= 1'b0;
      res_valid          <= 1'b0;
      res_data           <= '0;
      mesh_x_vector_flat <= '0;
      mesh_global_state  <= GS_IDLE;
      mesh_cfg_valid     <= 1'b0;
      mesh_cfg_addr      <= '0;
      mesh_cfg_data      <= '0;
    end else begin
      // Config write is a single-cycle pulse per accepted beat
      mesh_cfg_valid <= 1'b0;

      if (w_fire) begin
        mesh_cfg_valid <= 1'b1;
        mesh_cfg_addr  <= {row_idx, col_idx};
        mesh_cfg_data  <= w_data;
        if (last_beat) begin
          row_idx        <= '0;
          col_idx        <= '0;
          weights_loaded <= 1'b1;
          state          <= ST_IDLE;
        end else begin
          // The set in the mesh is now partial until the final beat lands
          weights_loaded <= 1'b0;
          state          <= ST_CFG;
          if (last_col) begin
            col_idx <= '0;
            row_idx <= row_idx + 1'b1;
          end else begin
            col_idx <= col_idx + 1'b1;
          end
        end
      end

      case (state)
        ST_IDLE: begin
          if (x_fire) begin
            mesh_x_vector_flat <= x_data;
            mesh_global_state  <= GS_LOAD;
            phase_cnt          <= '0;
            state              <= ST_LOAD;
          end
        end

        ST_CFG: begin
          // Beats are consumed above; gaps in w_valid simply stall here
        end

        ST_LOAD: begin
          if (phase_cnt == PH_W'(ROWS - 1)) begin
            phase_cnt          <= '0;
            mesh_x_vector_flat <= '0;
            mesh_global_state  <= GS_ACC;
            state              <= ST_ACC;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        ST_ACC: begin
          if (phase_cnt == PH_W'(COLS - 1)) begin
            phase_cnt         <= '0;
            mesh_global_state <= GS_CAP;
            state             <= ST_CAP;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        ST_CAP: begin
          mesh_global_state <= GS_IDLE;
          state             <= ST_DRAIN;
        end

        ST_DRAIN: begin
          // Mesh results settle during CAP and are sampled here
          res_data  <= mesh_result_flat;
          res_valid <= 1'b1;
          state     <= ST_OUT;
        end

        ST_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          mesh_global_state <= GS_IDLE;
          state             <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MESH_CTRL_PERF_EN
  logic res_fire;
  assign res_fire = res_valid && res_ready;

  // Count consumed results; wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_vec_cnt <= '0;
    end else if (res_fire) begin
      perf_vec_cnt <= perf_vec_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mesh_array_ctrl.sv
// tb/tb_mesh_array_ctrl.sv - scoreboard bench for mesh_array_ctrl with a behavioural mesh
module tb_mesh_array_ctrl;

  localparam int DW    = 8;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int ROW_W = 2;
  localparam int COL_W = 2;
  localparam int ACC_W = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   w_valid;
  logic                   w_ready;
  logic [DW-1:0]          w_data;
  logic                   x_valid;
  logic                   x_ready;
  logic [COLS*DW-1:0]     x_data;
  logic                   res_valid;
  logic                   res_ready;
  logic [ROWS*ACC_W-1:0]  res_data;
  logic                   busy;
  logic                   weights_loaded;
  logic [COLS*DW-1:0]     mesh_x_vector_flat;
  logic [1:0]             mesh_global_state;
  logic                   mesh_cfg_valid;
  logic [ROW_W+COL_W-1:0] mesh_cfg_addr;
  logic [DW-1:0]          mesh_cfg_data;
  logic [ROWS*ACC_W-1:0]  mesh_res;
`ifdef MESH_CTRL_PERF_EN
  logic [31:0]            perf_vec_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int consumed = 0;
  int w_exp [ROWS][COLS];
  logic [11:0] cfg_q [$];
  logic [63:0] res_q [$];

  always #5 clk = ~clk;

  mesh_array_ctrl #(
    .DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .weights_loaded(weights_loaded),
    .mesh_x_vector_flat(mesh_x_vector_flat), .mesh_global_state(mesh_global_state),
    .mesh_cfg_valid(mesh_cfg_valid), .mesh_cfg_addr(mesh_cfg_addr), .mesh_cfg_data(mesh_cfg_data),
    .mesh_result_flat(mesh_res)
`ifdef MESH_CTRL_PERF_EN
    , .perf_vec_cnt(perf_vec_cnt)
`endif
  );

  // Behavioural mesh: weight store, vector capture in LOAD, result update in CAP
  logic signed [DW-1:0] w_mem [ROWS][COLS];
  logic [COLS*DW-1:0]   x_cap;

  function automatic logic [63:0] mesh_compute();
    logic [63:0] r_v;
    int acc;
    logic signed [7:0] xe;
    r_v = '0;
    for (int r = 0; r < ROWS; r++) begin
      acc = 0;
      for (int c = 0; c < COLS; c++) begin
        xe = x_cap[c*8 +: 8];
        acc += int'(w_mem[r][c]) * int'(xe);
      end
      r_v[r*16 +: 16] = acc[15:0];
    end
    return r_v;
  endfunction

  always @(posedge clk) begin
    if (mesh_cfg_valid) w_mem[mesh_cfg_addr[3:2]][mesh_cfg_addr[1:0]] <= mesh_cfg_data;
    if (mesh_global_state == 2'd1) begin
      x_cap    <= mesh_x_vector_flat;
      mesh_res <= '0;
    end
    if (mesh_global_state == 2'd3) mesh_res <= mesh_compute();
  end

  function automatic logic [31:0] pack_x(input int a, input int b, input int c, input int d);
    logic [31:0] v;
    v[7:0] = a[7:0]; v[15:8] = b[7:0]; v[23:16] = c[7:0]; v[31:24] = d[7:0];
    return v;
  endfunction

  function automatic logic [63:0] expect_rows(input logic [31:0] xd);
    logic [63:0] v;
    int acc;
    logic signed [7:0] xe;
    v = '0;
    for (int r = 0; r < ROWS; r++) begin
      acc = 0;
      for (int c = 0; c < COLS; c++) begin
        xe = xd[c*8 +: 8];
        acc += w_exp[r][c] * int'(xe);
      end
      v[r*16 +: 16] = acc[15:0];
    end
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; w_valid = 0; w_data = '0; x_valid = 0; x_data = '0; res_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL reset_w_ready got %b want 1", w_ready); end
    checks++; if (x_ready !== 1'b0) begin errors++; $display("FAIL reset_x_ready got %b want 0", x_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (weights_loaded !== 1'b0) begin errors++; $display("FAIL reset_wl got %b want 0", weights_loaded); end
    checks++; if (mesh_cfg_valid !== 1'b0) begin errors++; $display("FAIL reset_cfg_valid got %b want 0", mesh_cfg_valid); end
    checks++; if (mesh_global_state !== 2'd0) begin errors++; $display("FAIL reset_gs got %0d want 0", mesh_global_state); end
    checks++; if ({mesh_cfg_addr, mesh_cfg_data} !== 12'd0) begin errors++; $display("FAIL reset_cfg got %h want 0", {mesh_cfg_addr, mesh_cfg_data}); end
    checks++; if (mesh_x_vector_flat !== 32'd0) begin errors++; $display("FAIL reset_xvec got %h want 0", mesh_x_vector_flat); end
    checks++; if (res_data !== 64'd0) begin errors++; $display("FAIL reset_res_data got %h want 0", res_data); end
    rst = 1'b0;
  endtask

  task automatic test_no_weights();
    @(negedge clk);
    x_valid = 1'b1; x_data = pack_x(1, 2, 3, 4);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (x_ready !== 1'b0) begin errors++; $display("FAIL nowt_x_ready got %b want 0", x_ready); end
      @(posedge clk); @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nowt_busy got %b want 0", busy); end
    end
    x_valid = 1'b0;
  endtask

  task automatic load_weights(input int mode, input bit gaps, input bit hold_x);
    int val;
    logic [11:0] exp_c;
    @(negedge clk);
    if (hold_x) begin x_valid = 1'b1; x_data = pack_x(1, 1, 1, 1); end
    for (int k = 0; k < ROWS*COLS; k++) begin
      val = (mode == 0) ? k + 1 : 1;
      w_exp[k/COLS][k%COLS] = val;
      w_valid = 1'b1; w_data = val[7:0];
      #1;
      checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL cfg_w_ready beat %0d got %b want 1", k, w_ready); end
      if (hold_x) begin
        checks++; if (x_ready !== 1'b0) begin errors++; $display("FAIL prio_x_ready beat %0d got %b want 0", k, x_ready); end
      end
      cfg_q.push_back({k[3:0], val[7:0]});
      @(posedge clk); @(negedge clk);
      w_valid = 1'b0;
      exp_c = cfg_q.pop_front();
      checks++; if (mesh_cfg_valid !== 1'b1) begin errors++; $display("FAIL cfg_valid beat %0d got %b want 1", k, mesh_cfg_valid); end
      checks++; if ({mesh_cfg_addr, mesh_cfg_data} !== exp_c) begin errors++; $display("FAIL cfg_addr_data beat %0d got %h want %h", k, {mesh_cfg_addr, mesh_cfg_data}, exp_c); end
      if (k == 0) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cfg_enter_busy got %b want 1", busy); end
        checks++; if (weights_loaded !== 1'b0) begin errors++; $display("FAIL cfg_enter_wl got %b want 0", weights_loaded); end
      end
      if (gaps && (k % 5 == 2)) begin
        repeat (2) begin
          @(posedge clk); @(negedge clk);
          checks++; if (mesh_cfg_valid !== 1'b0) begin errors++; $display("FAIL gap_cfg_valid got %b want 0", mesh_cfg_valid); end
          checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy got %b want 1", busy); end
        end
      end
    end
    x_valid = 1'b0;
    checks++; if (weights_loaded !== 1'b1) begin errors++; $display("FAIL cfg_done_wl got %b want 1", weights_loaded); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfg_done_busy got %b want 0", busy); end
  endtask

  task automatic send_x(input logic [31:0] xd, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    x_valid = 1'b1; x_data = xd;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (x_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
  endtask

  task automatic test_vector(input logic [31:0] xd, input int hold);
    bit ok;
    int lat;
    logic [1:0] gs_e;
    logic [63:0] exp_v;
    logic [63:0] held;
    send_x(xd, ok);
    if (!ok) begin
      checks++; errors++; x_valid = 1'b0;
      $display("FAIL x_handshake timeout got x_ready=%b want 1", x_ready);
      return;
    end
    res_q.push_back(expect_rows(xd));
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      x_valid = 1'b0;
      if (n <= 10) begin
        gs_e = (n <= ROWS) ? 2'd1 : (n <= ROWS + COLS) ? 2'd2 : (n == ROWS + COLS + 1) ? 2'd3 : 2'd0;
        checks++; if (mesh_global_state !== gs_e) begin errors++; $display("FAIL gs cycle %0d got %0d want %0d", n, mesh_global_state, gs_e); end
        checks++; if (mesh_x_vector_flat !== ((n <= ROWS) ? xd : 32'd0)) begin errors++; $display("FAIL xvec cycle %0d got %h", n, mesh_x_vector_flat); end
      end
      if (res_valid === 1'b1) begin lat = n; break; end
    end
    checks++; if (lat != ROWS + COLS + 3) begin errors++; $display("FAIL res_latency got %0d want %0d", lat, ROWS + COLS + 3); end
    exp_v = res_q.pop_front();
    if (lat == 0) return;
    checks++; if (res_data !== exp_v) begin errors++; $display("FAIL res_data got %h want %h", res_data, exp_v); end
    held = res_data;
    x_valid = 1'b1; x_data = xd;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk); #1;
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cycle %0d got %b want 1", h, res_valid); end
      checks++; if (res_data !== held) begin errors++; $display("FAIL hold_data cycle %0d got %h want %h", h, res_data, held); end
      checks++; if (x_ready !== 1'b0) begin errors++; $display("FAIL hold_x_ready cycle %0d got %b want 0", h, x_ready); end
    end
    x_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
    consumed++;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL post_valid got %b want 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    bit in_acc;
    send_x(pack_x(1, 2, 3, 4), ok);
    in_acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      x_valid = 1'b0;
      if (mesh_global_state === 2'd2) begin in_acc = 1'b1; break; end
    end
    checks++; if (!ok || !in_acc) begin errors++; $display("FAIL rstmid_reach_acc got ok=%b acc=%b want 1 1", ok, in_acc); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    checks++; if (mesh_global_state !== 2'd0) begin errors++; $display("FAIL rstmid_gs got %0d want 0", mesh_global_state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (weights_loaded !== 1'b0) begin errors++; $display("FAIL rstmid_wl got %b want 0", weights_loaded); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_res_valid got %b want 0", res_valid); end
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rstmid_no_result got res_valid=1 want 0"); end
    consumed = 0;
  endtask

  task automatic test_back_to_back();
    load_weights(0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) test_vector($urandom, 0);
`ifdef MESH_CTRL_PERF_EN
    checks++; if (perf_vec_cnt !== 32'd3) begin errors++; $display("FAIL perf_vec_cnt got %0d want 3", perf_vec_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_no_weights();
    load_weights(0, 1'b0, 1'b0);
    test_vector(pack_x(1, -2, 3, 4), 0);
    load_weights(1, 1'b1, 1'b1);
    test_vector(pack_x(1, 2, 3, 4), 5);
    checks++; if (res_data !== {4{16'd10}}) begin errors++; $display("FAIL ones_rows got %h want %h", res_data, {4{16'd10}}); end
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
